// File: rtl/i2c_arbiter_if.sv
// Requester and controller-side bundle for the i2c_arbiter.
// The arbiter takes the slave view; whoever drives requests takes master.
interface i2c_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [8*NUM_REQ-1:0]  req_dev_addr;
  logic [16*NUM_REQ-1:0] req_reg_data;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  ack_ok;
  logic                  timeout_err;
  logic                  busy;
  logic                  start;
  logic [7:0]            dev_addr;
  logic [15:0]           reg_data;
  logic                  ctrl_ready;
  logic                  ctrl_ack;

  modport slave (
    input  req, req_dev_addr, req_reg_data,
    input  ctrl_ready, ctrl_ack,
    output grant, done, ack_ok, timeout_err,
    output busy, start, dev_addr, reg_data
  );

  modport master (
    output req, req_dev_addr, req_reg_data,
    output ctrl_ready, ctrl_ack,
    input  grant, done, ack_ok, timeout_err,
    input  busy, start, dev_addr, reg_data
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ
// requesters, with NACK retry and a per-phase watchdog.
module i2c_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk_in,
  input  logic          reset_not,
  i2c_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      gidx_q;
  logic [IW-1:0]      sel;
  logic [NUM_REQ-1:0] grant_q;
  logic [2:0]         retry_q;
  logic [15:0]        timer_q;
  logic               ok_q;
  logic               terr_q;
  logic [7:0]         addr_q;
  logic [15:0]        data_q;

  logic arb;
  logic retry_inc;
  logic abort;
  logic fin_ok;
  logic tmo;
  logic timer_clr;
  logic in_phase;

  // Walk downward so the last hit is the one nearest the pointer.
  always_comb begin
    int idx;
    idx = 0;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.req[idx]) sel = IW'(idx);
    end
  end

  assign tmo      = (timer_q == 16'(TIMEOUT - 1));
  assign in_phase = (state_q == START) ||
                    (state_q == WAIT_DONE);

  always_comb begin
    state_d   = state_q;
    arb       = 1'b0;
    retry_inc = 1'b0;
    abort     = 1'b0;
    fin_ok    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|bus.req) && bus.ctrl_ready) begin
          arb     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = START;
      START: begin
        if (!bus.ctrl_ready) begin
          state_d = WAIT_DONE;
        end else if (tmo) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT_DONE: begin
        if (bus.ctrl_ready) begin
          if (bus.ctrl_ack) begin
            fin_ok  = 1'b1;
            state_d = RESP;
          end else if (retry_q < 3'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_d   = START;
          end else begin
            state_d = RESP;
          end
        end else if (tmo) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign timer_clr = (state_d != state_q) &&
                     ((state_d == START) ||
                      (state_d == WAIT_DONE));

  always_ff @(posedge clk_in or negedge reset_not) begin
    if (!reset_not) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset_not) begin
    if (!reset_not) begin
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      retry_q <= '0;
      timer_q <= '0;
      ok_q    <= 1'b0;
      terr_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      ok_q   <= fin_ok;
      terr_q <= terr_q | abort;
      if (arb) begin
        gidx_q  <= sel;
        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
        ptr_q   <= (int'(sel) == NUM_REQ - 1)
                   ? '0 : sel + IW'(1);
      end else if (state_q == RESP) begin
        grant_q <= '0;
      end
      if (state_q == LOAD) begin
        addr_q  <= bus.req_dev_addr[int'(gidx_q)*8 +: 8];
        data_q  <= bus.req_reg_data[int'(gidx_q)*16 +: 16];
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 3'd1;
      end
      if (timer_clr) begin
        timer_q <= '0;
      end else if (in_phase) begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = (state_q == RESP) ? grant_q : '0;
  assign bus.ack_ok      = ok_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.start       = (state_q == START);
  assign bus.dev_addr    = addr_q;
  assign bus.reg_data    = data_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a behavioural controller model
// and a queue of expected completions checked on each done pulse.
module tb_i2c_arbiter;

  localparam int NR = 2;

  typedef struct packed {
    logic [1:0]  grant;
    logic        ack;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic clk_in    = 1'b0;
  logic reset_not = 1'b0;

  i2c_arbiter_if #(.NUM_REQ(NR)) bus();

  i2c_arbiter #(
    .NUM_REQ  (NR),
    .MAX_RETRY(3),
    .TIMEOUT  (255)
  ) dut (
    .clk_in   (clk_in),
    .reset_not(reset_not),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  int cyc       = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int fall_cyc  = 0;
  int done_cyc  = 0;
  bit start_prev = 1'b0;

  int busy_cnt   = 0;
  int resp_cnt   = 0;
  int nack_base  = 0;
  int nack_total = 0;
  bit hang_mode  = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Controller model: busy 4 cycles per start unless hung.
  always @(negedge clk_in) begin
    if (!reset_not) begin
      busy_cnt       = 0;
      bus.ctrl_ready = 1'b1;
      bus.ctrl_ack   = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        bus.ctrl_ack   = ((resp_cnt - nack_base) >= nack_total);
        resp_cnt++;
        bus.ctrl_ready = 1'b1;
      end
    end else if (!bus.ctrl_ready) begin
      if (!hang_mode) bus.ctrl_ready = 1'b1;
    end else if (bus.start) begin
      bus.ctrl_ready = 1'b0;
      if (!hang_mode) busy_cnt = 4;
    end
  end

  // Monitor and scoreboard.
  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    check("grant_onehot", 32'($onehot0(bus.grant)), 1);
    if (bus.start && !start_prev) start_cnt++;
    if (!bus.start && start_prev) fall_cyc = cyc;
    start_prev = bus.start;
    if (bus.done != '0) begin
      done_cnt++;
      done_cyc = cyc;
      if (q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 0);
      end else begin
        e = q.pop_front();
        check("done_owner", 32'(bus.done), 32'(e.grant));
        check("ack_ok", 32'(bus.ack_ok), 32'(e.ack));
        check("dev_addr", 32'(bus.dev_addr), 32'(e.addr));
        check("reg_data", 32'(bus.reg_data), 32'(e.data));
      end
    end
  end

  task automatic do_reset();
    reset_not = 1'b0;
    repeat (3) @(negedge clk_in);
    reset_not = 1'b1;
  endtask

  task automatic wait_grant(input int lim);
    int n = 0;
    while (bus.grant == '0 && n < lim) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= lim) check("grant_wait_expired", 32'(n), 0);
  endtask

  task automatic wait_done_pulse(input int lim);
    int n = 0;
    while (bus.done == '0 && n < lim) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= lim) check("done_wait_expired", 32'(n), 0);
  endtask

  initial begin
    int s0;
    bus.req          = '0;
    bus.req_dev_addr = '0;
    bus.req_reg_data = '0;
    repeat (2) @(negedge clk_in);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_flags",
          32'({bus.ack_ok, bus.timeout_err, bus.busy, bus.start}), 0);
    check("rst_dev_addr", 32'(bus.dev_addr), 0);
    check("rst_reg_data", 32'(bus.reg_data), 0);
    reset_not = 1'b1;
    @(negedge clk_in);

    // Single request, requester drops req after grant.
    bus.req_dev_addr = {8'h00, 8'h72};
    bus.req_reg_data = {16'h0000, 16'h9803};
    q.push_back('{2'b01, 1'b1, 8'h72, 16'h9803});
    s0 = start_cnt;
    bus.req = 2'b01;
    wait_grant(20);
    check("single_grant", 32'(bus.grant), 32'h1);
    bus.req = 2'b00;
    wait_done_pulse(50);
    @(negedge clk_in);
    check("done_one_cycle", 32'(bus.done), 0);
    check("single_starts", 32'(start_cnt - s0), 1);
    check("idle_grant", 32'(bus.grant), 0);
    check("idle_busy", 32'(bus.busy), 0);

    // Contention: held 11 gives 01,10,01.
    do_reset();
    bus.req_dev_addr = {8'h20, 8'h10};
    bus.req_reg_data = {16'h2222, 16'h1111};
    q.push_back('{2'b01, 1'b1, 8'h10, 16'h1111});
    q.push_back('{2'b10, 1'b1, 8'h20, 16'h2222});
    q.push_back('{2'b01, 1'b1, 8'h10, 16'h1111});
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_done_pulse(60);
      if (i == 2) bus.req = 2'b00;
      @(negedge clk_in);
    end
    check("contention_drained", 32'(q.size()), 0);

    // NACK four times with MAX_RETRY=3.
    do_reset();
    bus.req_dev_addr = {8'h20, 8'h33};
    bus.req_reg_data = {16'h2222, 16'hA55A};
    nack_base  = resp_cnt;
    nack_total = 4;
    s0 = start_cnt;
    q.push_back('{2'b01, 1'b0, 8'h33, 16'hA55A});
    bus.req = 2'b01;
    wait_grant(20);
    bus.req = 2'b00;
    wait_done_pulse(200);
    @(negedge clk_in);
    check("nack_starts", 32'(start_cnt - s0), 4);
    check("nack_no_timeout", 32'(bus.timeout_err), 0);
    nack_total = 0;

    // Controller hang: abort 255 cycles after entering WAIT_DONE.
    hang_mode = 1'b1;
    q.push_back('{2'b10, 1'b0, 8'h20, 16'h2222});
    bus.req = 2'b10;
    wait_grant(20);
    bus.req = 2'b00;
    wait_done_pulse(400);
    @(negedge clk_in);
    check("hang_cycles", 32'(done_cyc - fall_cyc), 255);
    check("hang_terr", 32'(bus.timeout_err), 1);
    hang_mode = 1'b0;
    repeat (3) @(negedge clk_in);
    check("terr_sticky", 32'(bus.timeout_err), 1);

    // Requester data changes after LOAD are ignored.
    bus.req_dev_addr = {8'h20, 8'h5A};
    bus.req_reg_data = {16'h2222, 16'h1234};
    q.push_back('{2'b01, 1'b1, 8'h5A, 16'h1234});
    bus.req = 2'b01;
    wait_grant(20);
    @(negedge clk_in);
    bus.req_reg_data = {16'h2222, 16'hFFFF};
    bus.req = 2'b00;
    @(negedge clk_in);
    check("latched_data", 32'(bus.reg_data), 32'h1234);
    wait_done_pulse(60);
    @(negedge clk_in);
    check("terr_still_set", 32'(bus.timeout_err), 1);

    // Reset in WAIT_DONE: no done, restart from requester 0.
    hang_mode = 1'b1;
    bus.req = 2'b01;
    wait_grant(20);
    repeat (2) @(negedge clk_in);
    check("pre_reset_busy", 32'(bus.busy), 1);
    #2 reset_not = 1'b0;
    #1;
    check("mid_rst_start", 32'(bus.start), 0);
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_terr", 32'(bus.timeout_err), 0);
    hang_mode = 1'b0;
    bus.req = 2'b10;
    repeat (3) @(negedge clk_in);
    q.push_back('{2'b10, 1'b1, 8'h20, 16'h2222});
    reset_not = 1'b1;
    wait_grant(20);
    check("post_rst_grant", 32'(bus.grant), 32'h2);
    bus.req = 2'b00;
    wait_done_pulse(60);
    repeat (2) @(negedge clk_in);
    check("queue_empty", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one i2c_controller (legal 2..4).
REQ-002 Parameter MAX_RETRY, default 3, re-issues of a NACKed transfer before reporting failure (0..7).
REQ-003 Parameter TIMEOUT, default 255, clk_in cycles allowed per controller phase before abort (1..65535).
REQ-004 clk_in  input  1  single clock, the i2c_controller clock domain; all logic on its rising edge.
REQ-005 reset_not  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester transfer request, level, bit i = requester i.
REQ-007 req_dev_addr  input  8*NUM_REQ  packed device addresses; bits [8i+7:8i] belong to requester i.
REQ-008 req_reg_data  input  16*NUM_REQ  packed {reg, value} words; bits [16i+15:16i] belong to requester i.
REQ-009 grant  output  NUM_REQ  one-hot owner of the controller; all zero when idle.
REQ-010 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 ack_ok  output  1  valid with done: 1 = device ACKed, 0 = retries exhausted or timeout.
REQ-012 timeout_err  output  1  sticky; set on any timeout abort, cleared only by reset.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 start  output  1  start strobe to i2c_controller.
REQ-015 dev_addr  output  8  device address to i2c_controller.
REQ-016 reg_data  output  16  register/data word to i2c_controller.
REQ-017 ctrl_ready  input  1  i2c_controller ready_out; high = idle and able to accept start.
REQ-018 ctrl_ack  input  1  i2c_controller ack; 1 = device ACKed, valid when ctrl_ready rises.

Function
REQ-019 States: IDLE, LOAD, START, WAIT_DONE, RESP; any unused encoding shall go to IDLE next cycle.
REQ-020 IDLE: when any req bit is high and ctrl_ready=1, select requester by round-robin, set grant, go to LOAD; otherwise stay.
REQ-021 Round-robin: search starts at pointer p (reset 0) upward, wrapping at NUM_REQ; after a grant to i, p = (i+1) mod NUM_REQ.
REQ-022 LOAD: latch the granted requester's dev_addr/reg_data into dev_addr/reg_data, clear the retry counter, go to START.
REQ-023 dev_addr/reg_data shall stay constant from LOAD until the transfer leaves RESP; requester input changes meanwhile are ignored.
REQ-024 START: hold start=1 until ctrl_ready is sampled 0, then drop start and go to WAIT_DONE.
REQ-025 WAIT_DONE: on ctrl_ready sampled 1, sample ctrl_ack; ack=1 goes to RESP with success.
REQ-026 NACK: if retry count < MAX_RETRY, increment it and return to START; else go to RESP with failure.
REQ-027 RESP: pulse done[granted]=1 for exactly one cycle with ack_ok, clear grant, go to IDLE.
REQ-028 Earliest re-grant is the cycle after RESP; a requester holding req high after done is treated as a new request.
REQ-029 Phase timer: 16-bit counter cleared on entry to START and WAIT_DONE, counting each cycle; reaching TIMEOUT aborts to RESP with ack_ok=0, sets timeout_err, drops start.
REQ-030 A requester dropping req after grant shall not abort; the transfer completes and done still pulses.
REQ-031 Simultaneous requests in IDLE: exactly one grant per arbitration, never more than one grant bit high.
REQ-032 No start shall be issued while ctrl_ready=0 in IDLE; arbitration waits.

Reset
REQ-033 reset_not=0 shall asynchronously force state=IDLE, p=0, retry=0, timer=0, and outputs grant=0, done=0, ack_ok=0, timeout_err=0, busy=0, start=0, dev_addr=8'h00, reg_data=16'h0000.
REQ-034 Reset mid-transfer shall drop start within the reset assertion, not emit done, and restart arbitration at requester 0 after release.

Verification
REQ-035 Single request: req=2'b01, addr 8'h72, data 16'h9803, controller ACKs -> grant=01, start seen, dev_addr=72, reg_data=9803, done=01 one cycle, ack_ok=1.
REQ-036 Contention: req=2'b11 held through three transfers -> grant order 01,10,01; never two grant bits high.
REQ-037 NACK retry: controller NACKs 4 times, MAX_RETRY=3 -> exactly 4 start strobes, then done with ack_ok=0, timeout_err=0.
REQ-038 Hang: ctrl_ready stuck 0 after start, TIMEOUT=255 -> abort after 255 cycles in WAIT_DONE, done with ack_ok=0, timeout_err=1 stays set.
REQ-039 Reset mid-transfer: assert reset_not=0 in WAIT_DONE -> start=0, grant=0, no done pulse; after release with req=2'b10 grant=10 first.
REQ-040 Input change: modify req_reg_data to 16'hFFFF after LOAD -> reg_data output retains latched value until RESP.
